// File: rtl/key_poll_master.sv
// Avalon-MM poller for a push-button PIO: debounces each key and queues one-shot events.
// Optional: define KEY_POLL_RELEASE_EVT_EN to queue release events as well as presses.
module key_poll_master #(
  parameter int POLL_DIV     = 50000,
  parameter int WIDTH        = 2,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  output logic [WIDTH-1:0] keys_stable,
  output logic             evt_valid,
  output logic [3:0]       evt_data,
  input  logic             evt_ready,
  output logic             evt_overflow,
  input  logic             ovf_clr
);

  localparam int DIV_W = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 2;
  localparam int CNT_W = 4;

`ifdef KEY_POLL_RELEASE_EVT_EN
  localparam bit RELEASE_EN = 1'b1;
`else
  localparam bit RELEASE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SCAN
  } state_t;

  state_t             state, state_next;
  logic [DIV_W-1:0]   div;
  logic [2:0]         idx;
  logic [WIDTH-1:0]   sample;
  logic [WIDTH-1:0]   stable, stable_next;
  logic [CNT_W-1:0]   cnt      [WIDTH];
  logic [CNT_W-1:0]   cnt_next [WIDTH];
  logic               read_q;

  logic               push;
  logic [3:0]         push_data;

  logic [3:0]         fifo_mem [4];
  logic [1:0]         wr_ptr, rd_ptr;
  logic [2:0]         fifo_count;
  logic               fifo_full, fifo_empty;
  logic               pop, push_ok, drop;
  logic               ovf_q;

  // Only the key bits of the data register are meaningful.
  logic               unused_readdata;
  assign unused_readdata = ^avm_readdata[31:WIDTH];

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (div == DIV_W'(POLL_DIV - 1)) state_next = S_REQ;
      S_REQ:  if (!avm_waitrequest)            state_next = S_WAIT;
      S_WAIT:                                  state_next = S_SCAN;
      S_SCAN: if (idx == 3'(WIDTH - 1))        state_next = S_IDLE;
      default:                                 state_next = S_IDLE;
    endcase
  end

  // Debounce decision for the one key selected by idx during SCAN.
  always_comb begin
    stable_next = stable;
    push        = 1'b0;
    push_data   = 4'b0000;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = cnt[i];
      if (state == S_SCAN && idx == 3'(i)) begin
        if (sample[i] == stable[i]) begin
          cnt_next[i] = '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CNT - 1)) begin
          cnt_next[i]    = '0;
          stable_next[i] = ~stable[i];
          push           = RELEASE_EN | ~stable[i];
          push_data      = {~stable[i], 3'(i)};
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      div    <= '0;
      idx    <= '0;
      sample <= '0;
      stable <= '0;
      read_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      state  <= state_next;
      read_q <= (state_next == S_REQ);
      div    <= (state == S_IDLE && state_next == S_IDLE) ? div + 1'b1 : '0;
      if (state == S_WAIT) begin
        sample <= ~avm_readdata[WIDTH-1:0];
        idx    <= '0;
      end else if (state == S_SCAN) begin
        idx <= idx + 3'd1;
      end
      stable <= stable_next;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
    end
  end

  assign fifo_full  = (fifo_count == 3'd4);
  assign fifo_empty = (fifo_count == 3'd0);
  assign pop        = !fifo_empty && evt_ready;
  assign push_ok    = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;

  // NOTE: the event storage has no reset; occupancy is tracked by fifo_count, and the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
      // A drop wins over a simultaneous clear so no lost event goes unreported.
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign avm_address  = 2'b00;
  assign avm_read     = read_q;
  assign keys_stable  = stable;
  assign evt_valid    = !fifo_empty;
  assign evt_data     = fifo_empty ? 4'b0000 : fifo_mem[rd_ptr];
  assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_key_poll_master.sv
// Self-checking bench for key_poll_master: registered PIO slave model, debounce reference
// model feeding an event scoreboard, a per-poll vector table and FIFO corner sequences.
module tb_key_poll_master;

  localparam int DB = 3;

`ifdef KEY_POLL_RELEASE_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [1:0]  keys_stable;
  logic        evt_valid;
  logic [3:0]  evt_data;
  logic        evt_ready;
  logic        evt_overflow;
  logic        ovf_clr;

  key_poll_master #(.POLL_DIV(4), .WIDTH(2), .DEBOUNCE_CNT(DB)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .keys_stable     (keys_stable),
    .evt_valid       (evt_valid),
    .evt_data        (evt_data),
    .evt_ready       (evt_ready),
    .evt_overflow    (evt_overflow),
    .ovf_clr         (ovf_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus state shared with the slave / reference model.
  logic [1:0]  press = 2'b00;  // 1 = pressed
  bit          sb_en = 1'b1;
  bit          ready_auto = 1'b0;
  logic [31:0] rd_q;
  logic [1:0]  m_stable;
  int          m_cnt [2];
  int          m_evt_count = 0;
  logic [3:0]  m_last = 4'h0;
  logic [3:0]  exp_q [$];

  assign avm_readdata = rd_q;

  // Slave returns data one cycle after acceptance, all-pressed garbage otherwise;
  // the reference debouncer consumes each accepted sample and predicts queued events.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q     <= 32'h0;
      m_stable = 2'b00;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      exp_q.delete();
    end else begin
      if (evt_valid && evt_ready && sb_en) begin
        if (exp_q.size() == 0) check("sb_extra_evt", 32'(evt_data), 32'hFFFF_FFFF);
        else                   check("sb_evt", 32'(evt_data), 32'(exp_q.pop_front()));
      end
      rd_q <= (avm_read && !avm_waitrequest) ? {30'b0, ~press} : 32'h0;
      if (avm_read && !avm_waitrequest) begin
        for (int i = 0; i < 2; i++) begin
          if (press[i] == m_stable[i]) begin
            m_cnt[i] = 0;
          end else if (m_cnt[i] + 1 == DB) begin
            m_stable[i] = ~m_stable[i];
            m_cnt[i]    = 0;
            if (m_stable[i] || REL_EN) begin
              m_evt_count++;
              m_last = {m_stable[i], 3'(i)};
              if (sb_en) exp_q.push_back(m_last);
            end
          end else begin
            m_cnt[i]++;
          end
        end
      end
    end
  end

  // One complete poll; act 1 pops, act 2 pulses ovf_clr, on the key0 push edge if this poll pushes.
  task automatic run_poll(input logic [1:0] p, input int ws, input int act, output bit hit);
    int n;
    int c0;
    press = p;
    hit   = 1'b0;
    n     = 0;
    while (!avm_read && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!avm_read) begin
      check("poll_timeout", 32'(avm_read), 32'h1);
      return;
    end
    if (ws > 0) begin
      avm_waitrequest = 1'b1;
      for (int k = 0; k < ws; k++) begin
        @(posedge clk); #1;
        check("read_held", 32'(avm_read), 32'h1);
      end
      avm_waitrequest = 1'b0;
    end
    c0 = m_evt_count;
    @(posedge clk); #1;
    check("read_one_shot", 32'(avm_read), 32'h0);
    hit = (m_evt_count != c0);
    @(posedge clk); #1;
    if (hit && act == 1) evt_ready = 1'b1;
    if (hit && act == 2) ovf_clr = 1'b1;
    @(posedge clk); #1;
    evt_ready = ready_auto;
    ovf_clr   = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [1:0] pat(input int j);
    return (((j / 3) % 2) == 0) ? 2'b01 : 2'b00;
  endfunction

  int jpat = 0;

  task automatic poll_until_hit(input int act, output bit hit);
    hit = 1'b0;
    for (int g = 0; g < 30 && !hit; g++) begin
      run_poll(pat(jpat), 0, act, hit);
      jpat++;
    end
  endtask

  typedef struct {
    logic [1:0] press;
    int         ws;
    logic [1:0] stable;
  } vec_t;

  vec_t tbl [19];

  initial begin
    bit         hit;
    bit         early;
    int         base;
    int         n;
    logic [3:0] d;

    tbl[0]  = '{2'b01, 0, 2'b00};
    tbl[1]  = '{2'b00, 0, 2'b00};
    tbl[2]  = '{2'b01, 0, 2'b00};
    tbl[3]  = '{2'b01, 0, 2'b00};
    tbl[4]  = '{2'b01, 0, 2'b01};
    tbl[5]  = '{2'b11, 5, 2'b01};
    tbl[6]  = '{2'b11, 0, 2'b01};
    tbl[7]  = '{2'b11, 2, 2'b11};
    tbl[8]  = '{2'b00, 0, 2'b11};
    tbl[9]  = '{2'b00, 0, 2'b11};
    tbl[10] = '{2'b00, 0, 2'b00};
    tbl[11] = '{2'b10, 1, 2'b00};
    tbl[12] = '{2'b00, 0, 2'b00};
    tbl[13] = '{2'b10, 0, 2'b00};
    tbl[14] = '{2'b10, 0, 2'b00};
    tbl[15] = '{2'b10, 0, 2'b10};
    tbl[16] = '{2'b00, 0, 2'b10};
    tbl[17] = '{2'b00, 0, 2'b10};
    tbl[18] = '{2'b00, 0, 2'b00};

    reset_n         = 1'b0;
    avm_waitrequest = 1'b0;
    evt_ready       = 1'b0;
    ovf_clr         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read", 32'(avm_read), 32'h0);
    check("rst_addr", 32'(avm_address), 32'h0);
    check("rst_stable", 32'(keys_stable), 32'h0);
    check("rst_valid", 32'(evt_valid), 32'h0);
    check("rst_data", 32'(evt_data), 32'h0);
    check("rst_ovf", 32'(evt_overflow), 32'h0);

    // First read lands exactly POLL_DIV edges after release.
    reset_n = 1'b1;
    early   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      early |= avm_read;
    end
    check("first_read_early", 32'(early), 32'h0);
    @(posedge clk); #1;
    check("first_read_at_4", 32'(avm_read), 32'h1);
    run_poll(2'b00, 0, 0, hit);
    check("idle_stable", 32'(keys_stable), 32'h0);
    check("idle_no_evt", 32'(evt_valid), 32'h0);

    // Key0 held for DEBOUNCE_CNT polls produces one press event.
    for (int k = 0; k < 3; k++) begin
      run_poll(2'b01, 0, 0, hit);
      if (k == 1) check("press_not_yet", 32'(evt_valid), 32'h0);
    end
    check("press_stable", 32'(keys_stable), 32'h1);
    check("press_valid", 32'(evt_valid), 32'h1);
    check("press_data", 32'(evt_data), 32'h8);
    evt_ready = 1'b1;
    @(posedge clk); #1;
    evt_ready = 1'b0;
    check("press_popped", 32'(evt_valid), 32'h0);

    // Release of key0: event only when release events are enabled.
    for (int k = 0; k < 3; k++) run_poll(2'b00, 0, 0, hit);
    check("release_stable", 32'(keys_stable), 32'h0);
    check("release_valid", 32'(evt_valid), 32'(REL_EN));
    check("release_data", 32'(evt_data), 32'h0);
    evt_ready = 1'b1;
    @(posedge clk); #1;
    evt_ready = 1'b0;
    check("release_drained", 32'(evt_valid), 32'h0);

    // Vector table with a free-running consumer; events go through the scoreboard.
    ready_auto = 1'b1;
    evt_ready  = 1'b1;
    foreach (tbl[v]) begin
      run_poll(tbl[v].press, tbl[v].ws, 0, hit);
      check($sformatf("tbl%0d_stable", v), 32'(keys_stable), 32'(tbl[v].stable));
    end
    repeat (2) @(posedge clk);
    #1;
    check("sb_all_seen", 32'(exp_q.size()), 32'h0);
    ready_auto = 1'b0;
    evt_ready  = 1'b0;

    // FIFO fill, overflow and clear priority with no consumer.
    sb_en = 1'b0;
    base  = m_evt_count;
    while ((m_evt_count - base) < 4 && jpat < 60) begin
      run_poll(pat(jpat), 0, 0, hit);
      jpat++;
      check("fill_no_ovf", 32'(evt_overflow), 32'h0);
    end
    check("fill_count", 32'(m_evt_count - base), 32'h4);
    check("fill_valid", 32'(evt_valid), 32'h1);
    poll_until_hit(0, hit);
    check("drop_hit", 32'(hit), 32'h1);
    check("drop_ovf", 32'(evt_overflow), 32'h1);
    poll_until_hit(2, hit);
    check("clr_drop_hit", 32'(hit), 32'h1);
    check("clr_vs_drop_ovf", 32'(evt_overflow), 32'h1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(evt_overflow), 32'h0);
    poll_until_hit(1, hit);
    check("push_pop_hit", 32'(hit), 32'h1);
    check("push_pop_full_ovf", 32'(evt_overflow), 32'h0);
    d = 4'h0;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", 32'(evt_valid), 32'h1);
      d         = evt_data;
      evt_ready = 1'b1;
      @(posedge clk); #1;
      evt_ready = 1'b0;
    end
    check("drain_last", 32'(d), 32'(m_last));
    check("drain_empty", 32'(evt_valid), 32'h0);
    evt_ready = 1'b1;
    @(posedge clk); #1;
    evt_ready = 1'b0;
    check("pop_empty_valid", 32'(evt_valid), 32'h0);
    check("pop_empty_data", 32'(evt_data), 32'h0);

    // Reset while a read is stalled in REQ with a queued event.
    poll_until_hit(0, hit);
    check("pre_rst_valid", 32'(evt_valid), 32'h1);
    n = 0;
    while (!avm_read && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    avm_waitrequest = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_read", 32'(avm_read), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_read", 32'(avm_read), 32'h0);
    check("mid_rst_valid", 32'(evt_valid), 32'h0);
    check("mid_rst_stable", 32'(keys_stable), 32'h0);
    avm_waitrequest = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    early   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      early |= avm_read;
    end
    check("rerst_read_early", 32'(early), 32'h0);
    @(posedge clk); #1;
    check("rerst_read_at_4", 32'(avm_read), 32'h1);
    run_poll(2'b00, 0, 0, hit);
    check("rerst_stable", 32'(keys_stable), 32'h0);
    check("rerst_no_evt", 32'(evt_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_poll_master.md
# key_poll_master

Avalon-MM read initiator that periodically polls a 2-bit push-button PIO slave (registered readdata, one-cycle read latency), debounces each key and queues press/release events in a 4-entry FIFO for the game-logic consumer. It sits between the SoC's key PIO and the Tetris input handler, so hardware sees clean, one-shot key events rather than raw switch levels.

## Interface

- POLL_DIV, 50000: clock cycles between poll reads (min 4).
- WIDTH, 2: number of keys polled, 1..8; uses readdata[WIDTH-1:0].
- DEBOUNCE_CNT, 4: consecutive differing samples required to flip a key's stable state (1..15).
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- avm_address  out  2  always 2'b00 (data register).
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall; request held while high.
- avm_readdata  in  32  read data, valid exactly 1 cycle after accepted read.
- keys_stable  out  WIDTH  debounced level, 1 = pressed.
- evt_valid  out  1  FIFO non-empty.
- evt_data  out  4  {pressed, key_index[2:0]} of FIFO head.
- evt_ready  in  1  consumer pop; pop occurs when evt_valid && evt_ready.
- evt_overflow  out  1  sticky: an event was dropped.
- ovf_clr  in  1  clears evt_overflow (single-cycle pulse).

## Operation

- Keys are active-low on the bus: readdata bit = 0 means pressed; sample = ~readdata[WIDTH-1:0].
- FSM states: IDLE, REQ, WAIT, SCAN.
- IDLE: divider counts 0..POLL_DIV-1; at POLL_DIV-1 -> REQ, divider cleared.
- REQ: avm_read=1; leaves when avm_waitrequest=0 that cycle -> WAIT.
- WAIT: capture sample from avm_readdata -> SCAN, index=0.
- SCAN: one key per cycle, index 0..WIDTH-1, then -> IDLE.
  - sample[i] == stable[i]: cnt[i] <= 0.
  - else cnt[i]+1 == DEBOUNCE_CNT: stable[i] toggles, cnt[i] <= 0, event {stable_new, i} pushed.
  - else cnt[i] <= cnt[i]+1.
- FIFO: 4 entries, first-in first-out, evt_data = head entry.
  - Push while full with no pop: event dropped, evt_overflow <= 1.
  - Push and pop same cycle while full: both succeed, no overflow.
  - Pop while empty: ignored.
  - ovf_clr and a dropping push in same cycle: evt_overflow stays 1.
- Reset (any time, including mid-read): FSM to IDLE, divider 0, all cnt 0, FIFO emptied; a pending slave read is abandoned.

## Timing

- Reset values: avm_read 0, avm_address 0, keys_stable 0, evt_valid 0, evt_data 0, evt_overflow 0.
- First avm_read assertion POLL_DIV cycles after reset release (zero waitrequest).
- Poll period = POLL_DIV + 1 (REQ) + waitrequest cycles + 1 (WAIT) + WIDTH (SCAN).
- keys_stable[i] and evt_valid update on the clock edge ending the SCAN cycle of key i; event visible the next cycle.
- Minimum press-to-event latency: DEBOUNCE_CNT polls.
- avm_read and avm_address registered; no combinational path from avm_readdata to outputs.

## Configuration

- KEY_POLL_RELEASE_EVT_EN defined: both press (evt_data[3]=1) and release (evt_data[3]=0) events pushed.
- Undefined: only press events pushed; release still updates keys_stable and clears cnt, but pushes nothing and cannot cause overflow.

## Test plan

- POLL_DIV=4, DEBOUNCE_CNT=3, readdata=32'h3 constant, no waitrequest -> avm_read first high at cycle 4 after reset release, one cycle wide, keys_stable=0, no events.
- readdata=32'h2 (key0 pressed) for 3 polls -> after 3rd SCAN keys_stable=2'b01, evt_data=4'b1000, evt_valid=1; pop with evt_ready -> evt_valid=0.
- Key0 bounces 2,3,2,2,2 -> no event until 3 consecutive pressed samples (5th poll).
- waitrequest held high 5 cycles -> avm_read stays high all 6 REQ cycles, sample taken from readdata 1 cycle after acceptance.
- Both keys toggled repeatedly, evt_ready=0 -> 4 events queued, 5th drops, evt_overflow=1; ovf_clr -> 0; pop+push on full -> no overflow.
- Release key0 with macro undefined -> keys_stable=0, no event; with KEY_POLL_RELEASE_EVT_EN -> evt_data=4'b0000. Reset asserted during REQ -> avm_read 0 immediately, FIFO empty.
